// File: rtl/pc_select_ctrl_if.sv
// Control bundle between the ID/EX hazard area and the PC-select block.
// master = stimulus/pipeline side, slave = pc_select_ctrl.
interface pc_select_ctrl_if;
  logic       irq;
  logic       pc_supervisor;
  logic       id_jump;
  logic       id_jr;
  logic       id_undef;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_branch;
  logic       ex_taken;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic [2:0] PCSrc;
  logic       datahazard;
  logic       flush_ifid;
  logic       flush_idex;
  logic       irq_ack;

  modport master (
    output irq, pc_supervisor, id_jump, id_jr, id_undef, id_rs, id_rt,
           id_uses_rt, ex_branch, ex_taken, ex_memread, ex_rt,
    input  PCSrc, datahazard, flush_ifid, flush_idex, irq_ack
  );

  modport slave (
    input  irq, pc_supervisor, id_jump, id_jr, id_undef, id_rs, id_rt,
           id_uses_rt, ex_branch, ex_taken, ex_memread, ex_rt,
    output PCSrc, datahazard, flush_ifid, flush_idex, irq_ack
  );
endinterface

// File: rtl/pc_select_ctrl.sv
// One-cycle arbitration of branch / load-use / exception / jump / interrupt for the PC mux.
// Optional macro IRQ_SYNC_EN: irq goes through SYNC_STAGES flops instead of a single register.
module pc_select_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit EXC_ENABLE  = 1'b1
) (
  input logic            clk,
  input logic            reset,
  pc_select_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PENDING, ENTER, HANDLER} irq_state_e;

`ifdef IRQ_SYNC_EN
  localparam int NSYNC = SYNC_STAGES;
`else
  // Single capture register; SYNC_STAGES only shapes the synchronizer build.
  localparam int NSYNC = (SYNC_STAGES > 0) ? 1 : 1;
`endif

  irq_state_e       state_q, state_d;
  logic [NSYNC-1:0] sync_q, sync_d;
  logic             irq_s;
  logic             load_use;
  logic             take;

  assign irq_s = sync_q[NSYNC-1];

  always_comb begin
    sync_d[0] = bus.irq;
    for (int i = 1; i < NSYNC; i++) sync_d[i] = sync_q[i-1];
  end

  assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
    end
  end

  // Priority chain; reset forces the idle select and no strobes.
  always_comb begin
    bus.PCSrc      = 3'b000;
    bus.datahazard = 1'b0;
    bus.flush_ifid = 1'b0;
    bus.flush_idex = 1'b0;
    bus.irq_ack    = 1'b0;
    take           = 1'b0;
    if (!reset) begin
      if (bus.ex_branch) begin
        bus.PCSrc      = 3'b001;
        bus.flush_ifid = bus.ex_taken;
        bus.flush_idex = bus.ex_taken;
      end else if (load_use) begin
        bus.datahazard = 1'b1;
        bus.flush_idex = 1'b1;
      end else if (bus.id_undef && EXC_ENABLE) begin
        bus.PCSrc      = 3'b101;
        bus.flush_ifid = 1'b1;
        bus.flush_idex = 1'b1;
      end else if (bus.id_jr) begin
        bus.PCSrc      = 3'b011;
        bus.flush_ifid = 1'b1;
      end else if (bus.id_jump) begin
        bus.PCSrc      = 3'b010;
        bus.flush_ifid = 1'b1;
      end else if (state_q == PENDING && irq_s && !bus.pc_supervisor) begin
        bus.PCSrc      = 3'b100;
        bus.flush_ifid = 1'b1;
        bus.irq_ack    = 1'b1;
        take           = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (irq_s) state_d = PENDING;
      PENDING: if (!irq_s) state_d = IDLE;
               else if (take) state_d = ENTER;
      ENTER:   if (bus.pc_supervisor) state_d = HANDLER;
      HANDLER: if (!bus.pc_supervisor) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_select_ctrl.sv
// Scoreboard bench: two DUTs (EXC_ENABLE=1 and 0) share stimulus; a behavioural model predicts each.
module tb_pc_select_ctrl;
  localparam int SYNC_STAGES = 2;
`ifdef IRQ_SYNC_EN
  localparam int LAT = SYNC_STAGES;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic rst, irq, sup, jump, jr, undef;
    logic [4:0] rs, rt;
    logic uses_rt, br, tk, mr;
    logic [4:0] ert;
  } stim_t;
  typedef struct packed {logic [2:0] pcsrc; logic dh, fi, fx, ack;} resp_t;
  typedef struct packed {resp_t a, b;} exp_t;
  // Interrupt life stage in the model: waiting for request, request seen,
  // vector taken and waiting for kernel mode, running in kernel.
  typedef struct packed {bit seen, to_kernel, in_kernel;} mstate_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_select_ctrl_if bus_a();
  pc_select_ctrl_if bus_b();

  pc_select_ctrl #(.SYNC_STAGES(SYNC_STAGES), .EXC_ENABLE(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pc_select_ctrl #(.SYNC_STAGES(SYNC_STAGES), .EXC_ENABLE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.irq           = bus_a.irq;
  assign bus_b.pc_supervisor = bus_a.pc_supervisor;
  assign bus_b.id_jump       = bus_a.id_jump;
  assign bus_b.id_jr         = bus_a.id_jr;
  assign bus_b.id_undef      = bus_a.id_undef;
  assign bus_b.id_rs         = bus_a.id_rs;
  assign bus_b.id_rt         = bus_a.id_rt;
  assign bus_b.id_uses_rt    = bus_a.id_uses_rt;
  assign bus_b.ex_branch     = bus_a.ex_branch;
  assign bus_b.ex_taken      = bus_a.ex_taken;
  assign bus_b.ex_memread    = bus_a.ex_memread;
  assign bus_b.ex_rt         = bus_a.ex_rt;

  exp_t    sb[$];
  bit      irq_hist[$];
  mstate_t ms[2];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc_no  = 0;

  task automatic model(input stim_t s, input bit exc_en, input bit irq_s,
                       inout mstate_t m, output resp_t r);
    bit lu, took;
    r = '0;
    took = 1'b0;
    lu = s.mr && (s.ert != 0) && ((s.ert == s.rs) || (s.uses_rt && s.ert == s.rt));
    if (s.rst) begin
      m = '0;
      return;
    end
    if (s.br) begin
      r.pcsrc = 3'd1; r.fi = s.tk; r.fx = s.tk;
    end else if (lu) begin
      r.dh = 1'b1; r.fx = 1'b1;
    end else if (s.undef && exc_en) begin
      r.pcsrc = 3'd5; r.fi = 1'b1; r.fx = 1'b1;
    end else if (s.jr) begin
      r.pcsrc = 3'd3; r.fi = 1'b1;
    end else if (s.jump) begin
      r.pcsrc = 3'd2; r.fi = 1'b1;
    end else if (m.seen && irq_s && !s.sup) begin
      r.pcsrc = 3'd4; r.fi = 1'b1; r.ack = 1'b1; took = 1'b1;
    end
    if (m.to_kernel) begin
      m.to_kernel = !s.sup; m.in_kernel = s.sup;
    end else if (m.in_kernel) begin
      m.in_kernel = s.sup;
    end else if (m.seen) begin
      m.seen = irq_s && !took; m.to_kernel = took;
    end else begin
      m.seen = irq_s;
    end
  endtask

  task automatic cyc(input stim_t s);
    exp_t e;
    bit   irq_s;
    @(posedge clk); #1;
    reset                 = s.rst;
    bus_a.irq             = s.irq;
    bus_a.pc_supervisor   = s.sup;
    bus_a.id_jump         = s.jump;
    bus_a.id_jr           = s.jr;
    bus_a.id_undef        = s.undef;
    bus_a.id_rs           = s.rs;
    bus_a.id_rt           = s.rt;
    bus_a.id_uses_rt      = s.uses_rt;
    bus_a.ex_branch       = s.br;
    bus_a.ex_taken        = s.tk;
    bus_a.ex_memread      = s.mr;
    bus_a.ex_rt           = s.ert;
    irq_s = irq_hist[0];
    model(s, 1'b1, irq_s, ms[0], e.a);
    model(s, 1'b0, irq_s, ms[1], e.b);
    sb.push_back(e);
    // irq seen by the DUT LAT edges later; reset clears the capture chain
    if (s.rst) begin
      foreach (irq_hist[i]) irq_hist[i] = 1'b0;
    end else begin
      irq_hist.push_back(s.irq);
      void'(irq_hist.pop_front());
    end
  endtask

  initial begin : monitor
    exp_t  e;
    resp_t ga, gb;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ga = {bus_a.PCSrc, bus_a.datahazard, bus_a.flush_ifid, bus_a.flush_idex, bus_a.irq_ack};
        gb = {bus_b.PCSrc, bus_b.datahazard, bus_b.flush_ifid, bus_b.flush_idex, bus_b.irq_ack};
        cyc_no++;
        n_tests++;
        if (ga !== e.a) begin
          n_fail++;
          $display("FAIL exc_on cyc %0d: got pcsrc=%b dh/fi/fx/ack=%b%b%b%b, need pcsrc=%b dh/fi/fx/ack=%b%b%b%b",
                   cyc_no, ga.pcsrc, ga.dh, ga.fi, ga.fx, ga.ack, e.a.pcsrc, e.a.dh, e.a.fi, e.a.fx, e.a.ack);
        end
        n_tests++;
        if (gb !== e.b) begin
          n_fail++;
          $display("FAIL exc_off cyc %0d: got pcsrc=%b dh/fi/fx/ack=%b%b%b%b, need pcsrc=%b dh/fi/fx/ack=%b%b%b%b",
                   cyc_no, gb.pcsrc, gb.dh, gb.fi, gb.fx, gb.ack, e.b.pcsrc, e.b.dh, e.b.fi, e.b.fx, e.b.ack);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s, idle;
    for (int i = 0; i < LAT; i++) irq_hist.push_back(1'b0);
    ms[0] = '0;
    ms[1] = '0;
    idle = '0;

    // reset held with irq and branch asserted, then the irq gets through
    s = idle; s.rst = 1; s.irq = 1; s.br = 1; s.tk = 1;
    repeat (3) cyc(s);
    s = idle; s.irq = 1;
    repeat (LAT + 3) cyc(s);
    s = idle; s.sup = 1; repeat (3) cyc(s);
    s = idle; repeat (LAT + 3) cyc(s);

    // load-use, then ex_rt == 0
    s = idle; s.mr = 1; s.ert = 5; s.rs = 5; cyc(s);
    s.ert = 0; s.rs = 0; cyc(s);
    s = idle; s.mr = 1; s.ert = 7; s.rt = 7; s.uses_rt = 1; cyc(s);
    s.uses_rt = 0; cyc(s);

    // branch beats stall and jump
    s = idle; s.br = 1; s.tk = 1; s.mr = 1; s.ert = 5; s.rs = 5; s.jump = 1; cyc(s);
    s.tk = 0; cyc(s);

    // exception vs jump, and jr vs jump
    s = idle; s.undef = 1; s.jump = 1; cyc(s);
    s = idle; s.jr = 1; s.jump = 1; cyc(s);

    // interrupt lifecycle
    s = idle; s.irq = 1; repeat (LAT + 3) cyc(s);
    s.sup = 1; repeat (10) cyc(s);
    s.sup = 0; repeat (LAT + 4) cyc(s);
    s.sup = 1; repeat (3) cyc(s);
    s = idle; repeat (LAT + 3) cyc(s);

    // masked pending, dropped before user mode returns
    s = idle; s.sup = 1; s.irq = 1; repeat (20) cyc(s);
    s.irq = 0; repeat (LAT + 3) cyc(s);
    s.sup = 0; repeat (6) cyc(s);

    // randomized traffic with slowly moving irq/supervisor levels
    s = idle;
    for (int n = 0; n < 3000; n++) begin
      s.rst     = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) s.irq = ~s.irq;
      if ($urandom_range(9) == 0)  s.sup = ~s.sup;
      s.jump    = ($urandom_range(9) == 0);
      s.jr      = ($urandom_range(9) == 0);
      s.undef   = ($urandom_range(9) == 0);
      s.rs      = 5'($urandom_range(3));
      s.rt      = 5'($urandom_range(3));
      s.uses_rt = 1'($urandom);
      s.br      = ($urandom_range(6) == 0);
      s.tk      = 1'($urandom);
      s.mr      = ($urandom_range(2) == 0);
      s.ert     = 5'($urandom_range(3));
      cyc(s);
    end

    @(negedge clk); #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left, need 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_select_ctrl.md
Name: pc_select_ctrl

Overview:
- Drives the control inputs of the pipeline program counter: PCSrc[2:0] and datahazard.
- Arbitrates, in one cycle, between taken branches in EX, load-use stalls, J/JR in ID, undefined-instruction exceptions and an external interrupt.
- Also produces the IF/ID and ID/EX flush strobes.
- Sits beside the hazard logic between the ID/EX stages and the PC register.

Parameters:
- SYNC_STAGES, 2, number of irq synchronizer flops; range 2..4; used only when IRQ_SYNC_EN is defined.
- EXC_ENABLE, 1, 1 = id_undef raises PCSrc 101; 0 = id_undef ignored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  1  external interrupt request, level, asynchronous to clk.
- pc_supervisor  in  1  PC[31] of the instruction currently in IF.
- id_jump  in  1  J/JAL decoded in ID.
- id_jr  in  1  JR/JALR decoded in ID.
- id_undef  in  1  undefined opcode decoded in ID.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_branch  in  1  branch instruction in EX.
- ex_taken  in  1  ALUOut branch-condition bit from EX.
- ex_memread  in  1  load instruction in EX.
- ex_rt  in  5  destination rt of the EX load.
- PCSrc  out  3  PC next-address select.
- datahazard  out  1  freezes PC and IF/ID.
- flush_ifid  out  1  zero the IF/ID register.
- flush_idex  out  1  insert a bubble into ID/EX.
- irq_ack  out  1  one-cycle pulse when the interrupt is taken; also the EPC capture strobe.

Behaviour:
- PCSrc encoding (fixed): 000 = PC+4; 001 = branch (PC picks ConBA when ALUOut=1); 010 = jump; 011 = jr; 100 = interrupt vector 0x80000004; 101 = exception vector 0x80000008.
- Outputs are combinational from the inputs plus registered irq state.
- reset=1 at a rising edge: irq state := IDLE, synchronizer := 0. While reset is held, PCSrc=000 and all other outputs are 0.
- load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority (highest first), exactly one action per cycle:
  1. ex_branch: PCSrc=001. If ex_taken: flush_ifid=1, flush_idex=1. Otherwise no flush. The ID instruction's stall, undef and jump are ignored this cycle.
  2. load_use: datahazard=1, flush_idex=1, PCSrc=000.
  3. id_undef & EXC_ENABLE: PCSrc=101, flush_ifid=1, flush_idex=1.
  4. id_jr: PCSrc=011, flush_ifid=1.
  5. id_jump: PCSrc=010, flush_ifid=1.
  6. irq take (see below): PCSrc=100, flush_ifid=1, irq_ack=1.
  7. Otherwise PCSrc=000 and all strobes 0.
- irq FSM states: IDLE, PENDING, ENTER, HANDLER.
  - IDLE -> PENDING when irq_s=1 (synchronized irq).
  - PENDING: take the interrupt when pc_supervisor=0 and no higher-priority action is active; then go to ENTER.
  - PENDING -> IDLE if irq_s drops before the interrupt is taken. The request is not latched.
  - ENTER: wait for pc_supervisor=1, then go to HANDLER.
  - HANDLER: wait for pc_supervisor=0 (return from handler), then go to IDLE.
  - No interrupt is taken in ENTER or HANDLER; there is no nesting.
- irq_ack is high only in the take cycle, never for two consecutive cycles.
- When pc_supervisor=1, PENDING holds indefinitely; the kernel is non-interruptible.
- Reset mid-handler: FSM returns to IDLE; a still-asserted irq is re-requested after the sync latency.
- ex_rt==0 never stalls.
- A stall is suppressed when ex_branch is set. Branch flush already kills ID; there is no stall-then-flush sequence.

Optional Feature:
- IRQ_SYNC_EN defined: irq passes through SYNC_STAGES flops. irq_s lags irq by SYNC_STAGES cycles, so the earliest irq_ack is SYNC_STAGES+1 cycles after irq rises.
- Not defined: irq passes through a single register. The earliest irq_ack is 2 cycles after irq rises.

Test Plan:
- Reset: hold reset 3 cycles with irq=1 and ex_branch=1 -> PCSrc=000, all strobes 0. After release with IRQ_SYNC_EN and SYNC_STAGES=2, irq_ack pulses 3 cycles later.
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> datahazard=1, flush_idex=1, PCSrc=000. Repeat with ex_rt=0 -> no stall.
- Branch priority: ex_branch=1, ex_taken=1, load_use=1, id_jump=1 -> PCSrc=001, flush_ifid=1, flush_idex=1, datahazard=0. With ex_taken=0 -> PCSrc=001 and no flushes.
- Exception vs jump: id_undef=1, id_jump=1 -> PCSrc=101 with both flushes. With EXC_ENABLE=0 -> PCSrc=010, flush_ifid only.
- Interrupt lifecycle:
  - irq=1, pc_supervisor=0 -> single irq_ack with PCSrc=100.
  - Next, pc_supervisor=1 for 10 cycles -> no further ack.
  - pc_supervisor back to 0 with irq still 1 -> second irq_ack after FSM passes IDLE -> PENDING.
- Masked pending: irq=1 while pc_supervisor=1 for 20 cycles -> no ack. Drop irq before pc_supervisor returns to 0 -> FSM returns to IDLE, no ack.
